// File: rtl/pc_unit.sv
// pc_unit -- program counter and branch resolution stage.
//
// Sits directly downstream of the ALU. Each cycle it combines the ALU ZERO
// flag with the branch controls from decode to pick the next instruction
// address, sequences start/halt for the core and counts RUN cycles.
//
// Parameters
//   PC_W   program counter width; address space is 2^PC_W words
//   CNT_W  cycle counter width
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RESET_N    asynchronous active-low reset
//   START      begin execution from address 0 (IDLE and HALTED only)
//   HALT       current instruction is a halt
//   STALL      hold the PC this cycle
//   BRANCH_EN  current instruction is a conditional branch
//   BR_NZ      0: branch if ZERO=1, 1: branch if ZERO=0
//   BR_ABS     1: absolute TARGET, 0: PC-relative OFFSET
//   ZERO       ALU zero flag for the current instruction
//   TARGET     absolute branch target
//   OFFSET     signed relative displacement
//   PC         current instruction address (registered)
//   TAKEN      one-cycle pulse after a taken branch (fetch flush)
//   DONE       high while halted
//   CYCLE_CNT  saturating count of RUN cycles since the last START

module pc_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic                    HALT,
    input  logic                    STALL,
    input  logic                    BRANCH_EN,
    input  logic                    BR_NZ,
    input  logic                    BR_ABS,
    input  logic                    ZERO,
    input  logic [PC_W-1:0]         TARGET,
    input  logic signed [7:0]       OFFSET,
    output logic [PC_W-1:0]         PC,
    output logic                    TAKEN,
    output logic                    DONE,
    output logic [CNT_W-1:0]        CYCLE_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}})
            return cnt;
        else
            return cnt + CNT_W'(1);
    endfunction

    // PC plus sign-extended displacement; the sum wraps modulo 2^PC_W in
    // both directions.
    function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0]   base,
                                                   input logic signed [7:0] disp);
        logic signed [PC_W-1:0] disp_ext;
        disp_ext = PC_W'(disp);
        return base + $unsigned(disp_ext);
    endfunction

    logic            br_taken;
    logic [PC_W-1:0] br_dest;

    // ZERO comes straight from the ALU in this same cycle.
    assign br_taken = BRANCH_EN & (ZERO ^ BR_NZ);
    assign br_dest  = BR_ABS ? TARGET : rel_target(PC, OFFSET);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            PC        <= '0;
            TAKEN     <= 1'b0;
            DONE      <= 1'b0;
            CYCLE_CNT <= '0;
        end else begin
            // TAKEN is a single-cycle pulse; only a taken branch in RUN sets it.
            TAKEN <= 1'b0;
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state     <= RUN;
                        PC        <= '0;
                        CYCLE_CNT <= '0;
                    end
                end

                RUN: begin
                    // Every RUN edge counts, stalled and halting ones included.
                    CYCLE_CNT <= sat_inc(CYCLE_CNT);
                    if (STALL) begin
                        // Multi-cycle instruction in flight: hold everything.
                        PC <= PC;
                    end else if (HALT) begin
                        // HALT outranks START and any branch on this edge.
                        state <= HALTED;
                        DONE  <= 1'b1;
                    end else if (br_taken) begin
                        PC    <= br_dest;
                        TAKEN <= 1'b1;
                    end else begin
                        PC <= PC + PC_W'(1);
                    end
                end

                HALTED: begin
                    DONE <= 1'b1;
                    if (START) begin
                        state     <= RUN;
                        PC        <= '0;
                        CYCLE_CNT <= '0;
                        DONE      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit.
module tb_pc_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    logic              CLK;
    logic              RESET_N;
    logic              START;
    logic              HALT;
    logic              STALL;
    logic              BRANCH_EN;
    logic              BR_NZ;
    logic              BR_ABS;
    logic              ZERO;
    logic [PC_W-1:0]   TARGET;
    logic signed [7:0] OFFSET;
    logic [PC_W-1:0]   PC;
    logic              TAKEN;
    logic              DONE;
    logic [CNT_W-1:0]  CYCLE_CNT;

    int n_vec = 0;
    int n_err = 0;

    // Expected cycle count: stepped on every edge the bench expects to be in RUN.
    int exp_cnt   = 0;
    bit model_run = 1'b0;

    pc_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .HALT      (HALT),
        .STALL     (STALL),
        .BRANCH_EN (BRANCH_EN),
        .BR_NZ     (BR_NZ),
        .BR_ABS    (BR_ABS),
        .ZERO      (ZERO),
        .TARGET    (TARGET),
        .OFFSET    (OFFSET),
        .PC        (PC),
        .TAKEN     (TAKEN),
        .DONE      (DONE),
        .CYCLE_CNT (CYCLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One rising edge, then settle 1 time unit so outputs are sampled away from it.
    task automatic tick();
        @(posedge CLK);
        if (model_run && exp_cnt < 65535) exp_cnt++;
        #1;
    endtask

    task automatic clear_branch();
        BRANCH_EN = 1'b0; BR_NZ = 1'b0; BR_ABS = 1'b0; ZERO = 1'b0;
        TARGET = '0; OFFSET = 8'sd0;
    endtask

    task automatic set_branch(input bit abs_mode, input bit nz, input bit z,
                              input logic [PC_W-1:0] tgt, input logic [7:0] off);
        BRANCH_EN = 1'b1; BR_ABS = abs_mode; BR_NZ = nz; ZERO = z;
        TARGET = tgt; OFFSET = off;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; START = 1'b0; HALT = 1'b0; STALL = 1'b0;
        clear_branch();
        #2;
        n_vec++;
        if (PC !== 10'd0 || TAKEN !== 1'b0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: PC=%0d TAKEN=%b DONE=%b CNT=%0d, required 0/0/0/0",
                     PC, TAKEN, DONE, CYCLE_CNT);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        n_vec++;
        if (PC !== 10'd0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL idle_hold: PC=%0d DONE=%b CNT=%0d, required 0/0/0", PC, DONE, CYCLE_CNT);
        end
    endtask

    task automatic test_sequential();
        START = 1'b1;
        tick();
        START = 1'b0;
        model_run = 1'b1;
        n_vec++;
        if (PC !== 10'd0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL start: PC=%0d CNT=%0d, required 0/0", PC, CYCLE_CNT);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_vec++;
            if (PC !== PC_W'(i) || CYCLE_CNT !== CNT_W'(i) || TAKEN !== 1'b0 || DONE !== 1'b0) begin
                n_err++;
                $display("FAIL seq_step%0d: PC=%0d CNT=%0d TAKEN=%b DONE=%b, required %0d/%0d/0/0",
                         i, PC, CYCLE_CNT, TAKEN, DONE, i, i);
            end
        end
    endtask

    task automatic test_branch_rel();
        for (int i = 0; i < 15; i++) tick();
        n_vec++;
        if (PC !== 10'd20) begin
            n_err++;
            $display("FAIL reach_20: PC=%0d, required 20", PC);
        end
        set_branch(1'b0, 1'b0, 1'b1, 10'd0, 8'hFC);
        tick();
        n_vec++;
        if (PC !== 10'd16 || TAKEN !== 1'b1 || CYCLE_CNT !== CNT_W'(exp_cnt)) begin
            n_err++;
            $display("FAIL rel_back_taken: PC=%0d TAKEN=%b CNT=%0d, required 16/1/%0d",
                     PC, TAKEN, CYCLE_CNT, exp_cnt);
        end
        clear_branch();
        tick();
        n_vec++;
        if (PC !== 10'd17 || TAKEN !== 1'b0) begin
            n_err++;
            $display("FAIL taken_one_cycle: PC=%0d TAKEN=%b, required 17/0", PC, TAKEN);
        end
        tick(); tick(); tick();
        set_branch(1'b0, 1'b0, 1'b0, 10'd0, 8'hFC);
        tick();
        n_vec++;
        if (PC !== 10'd21 || TAKEN !== 1'b0) begin
            n_err++;
            $display("FAIL rel_not_taken: PC=%0d TAKEN=%b, required 21/0", PC, TAKEN);
        end
        set_branch(1'b0, 1'b1, 1'b0, 10'd0, 8'd5);
        tick();
        n_vec++;
        if (PC !== 10'd26 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL bnz_fwd_taken: PC=%0d TAKEN=%b, required 26/1", PC, TAKEN);
        end
        clear_branch();
    endtask

    task automatic test_wrap();
        set_branch(1'b1, 1'b0, 1'b1, 10'd1023, 8'd0);
        tick();
        clear_branch();
        n_vec++;
        if (PC !== 10'd1023 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL abs_to_1023: PC=%0d TAKEN=%b, required 1023/1", PC, TAKEN);
        end
        tick();
        n_vec++;
        if (PC !== 10'd0 || TAKEN !== 1'b0) begin
            n_err++;
            $display("FAIL seq_wrap: PC=%0d TAKEN=%b, required 0/0", PC, TAKEN);
        end
        tick(); tick();
        set_branch(1'b0, 1'b0, 1'b1, 10'd0, 8'hFD);
        tick();
        n_vec++;
        if (PC !== 10'd1023 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL rel_wrap_down: PC=%0d TAKEN=%b, required 1023/1", PC, TAKEN);
        end
        set_branch(1'b0, 1'b1, 1'b0, 10'd0, 8'd3);
        tick();
        clear_branch();
        n_vec++;
        if (PC !== 10'd2 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL rel_wrap_up: PC=%0d TAKEN=%b, required 2/1", PC, TAKEN);
        end
    endtask

    task automatic test_back_to_back();
        set_branch(1'b1, 1'b0, 1'b1, 10'd7, 8'd0);
        tick();
        n_vec++;
        if (PC !== 10'd7 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first: PC=%0d TAKEN=%b, required 7/1", PC, TAKEN);
        end
        set_branch(1'b1, 1'b0, 1'b1, 10'd300, 8'd0);
        tick();
        clear_branch();
        n_vec++;
        if (PC !== 10'd300 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: PC=%0d TAKEN=%b, required 300/1", PC, TAKEN);
        end
        tick();
        n_vec++;
        if (PC !== 10'd301 || TAKEN !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_after: PC=%0d TAKEN=%b, required 301/0", PC, TAKEN);
        end
    endtask

    task automatic test_stall_halt();
        int c0;
        set_branch(1'b1, 1'b0, 1'b1, 10'd8, 8'd0);
        tick();
        // Keep a taken absolute branch and HALT asserted under the stall.
        set_branch(1'b1, 1'b0, 1'b1, 10'd500, 8'd0);
        HALT = 1'b1; STALL = 1'b1;
        c0 = exp_cnt;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if (PC !== 10'd8 || TAKEN !== 1'b0 || DONE !== 1'b0 || CYCLE_CNT !== CNT_W'(c0 + i)) begin
                n_err++;
                $display("FAIL stall%0d: PC=%0d TAKEN=%b DONE=%b CNT=%0d, required 8/0/0/%0d",
                         i, PC, TAKEN, DONE, CYCLE_CNT, c0 + i);
            end
        end
        STALL = 1'b0;
        tick();
        model_run = 1'b0;
        n_vec++;
        if (PC !== 10'd8 || TAKEN !== 1'b0 || DONE !== 1'b1 || CYCLE_CNT !== CNT_W'(c0 + 4)) begin
            n_err++;
            $display("FAIL halt_enter: PC=%0d TAKEN=%b DONE=%b CNT=%0d, required 8/0/1/%0d",
                     PC, TAKEN, DONE, CYCLE_CNT, c0 + 4);
        end
        HALT = 1'b0;
        tick(); tick();
        n_vec++;
        if (PC !== 10'd8 || TAKEN !== 1'b0 || DONE !== 1'b1 || CYCLE_CNT !== CNT_W'(c0 + 4)) begin
            n_err++;
            $display("FAIL halted_hold: PC=%0d TAKEN=%b DONE=%b CNT=%0d, required 8/0/1/%0d",
                     PC, TAKEN, DONE, CYCLE_CNT, c0 + 4);
        end
        clear_branch();
    endtask

    task automatic test_restart();
        START = 1'b1;
        tick();
        START = 1'b0;
        model_run = 1'b1; exp_cnt = 0;
        n_vec++;
        if (PC !== 10'd0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL restart: PC=%0d DONE=%b CNT=%0d, required 0/0/0", PC, DONE, CYCLE_CNT);
        end
        tick();
        n_vec++;
        if (PC !== 10'd1 || CYCLE_CNT !== 16'd1) begin
            n_err++;
            $display("FAIL restart_run: PC=%0d CNT=%0d, required 1/1", PC, CYCLE_CNT);
        end
        // START together with HALT in RUN: halt wins.
        START = 1'b1; HALT = 1'b1;
        tick();
        model_run = 1'b0;
        n_vec++;
        if (PC !== 10'd1 || DONE !== 1'b1 || CYCLE_CNT !== 16'd2) begin
            n_err++;
            $display("FAIL start_halt_same: PC=%0d DONE=%b CNT=%0d, required 1/1/2", PC, DONE, CYCLE_CNT);
        end
        HALT = 1'b0;
        tick();
        START = 1'b0;
        model_run = 1'b1; exp_cnt = 0;
        n_vec++;
        if (PC !== 10'd0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL restart2: PC=%0d DONE=%b CNT=%0d, required 0/0/0", PC, DONE, CYCLE_CNT);
        end
    endtask

    task automatic test_async_reset();
        set_branch(1'b1, 1'b0, 1'b1, 10'd50, 8'd0);
        tick();
        clear_branch();
        n_vec++;
        if (PC !== 10'd50 || TAKEN !== 1'b1) begin
            n_err++;
            $display("FAIL reach_50: PC=%0d TAKEN=%b, required 50/1", PC, TAKEN);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        model_run = 1'b0; exp_cnt = 0;
        n_vec++;
        if (PC !== 10'd0 || TAKEN !== 1'b0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: PC=%0d TAKEN=%b DONE=%b CNT=%0d, required 0/0/0/0",
                     PC, TAKEN, DONE, CYCLE_CNT);
        end
        tick();
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        n_vec++;
        if (PC !== 10'd0 || DONE !== 1'b0 || CYCLE_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: PC=%0d DONE=%b CNT=%0d, required 0/0/0", PC, DONE, CYCLE_CNT);
        end
    endtask

    task automatic test_saturation();
        START = 1'b1;
        tick();
        START = 1'b0;
        model_run = 1'b1; exp_cnt = 0;
        for (int i = 0; i < 65534; i++) tick();
        n_vec++;
        if (CYCLE_CNT !== 16'hFFFE) begin
            n_err++;
            $display("FAIL cnt_fffe: CNT=%h, required fffe", CYCLE_CNT);
        end
        tick();
        n_vec++;
        if (CYCLE_CNT !== 16'hFFFF) begin
            n_err++;
            $display("FAIL cnt_ffff: CNT=%h, required ffff", CYCLE_CNT);
        end
        tick(); tick(); tick();
        n_vec++;
        if (CYCLE_CNT !== 16'hFFFF || CYCLE_CNT !== CNT_W'(exp_cnt)) begin
            n_err++;
            $display("FAIL cnt_saturate: CNT=%h, required ffff", CYCLE_CNT);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_rel();
        test_wrap();
        test_back_to_back();
        test_stall_halt();
        test_restart();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and branch-resolution stage that sits directly downstream of the ALU. Each cycle it consumes the ALU's ZERO flag together with decode's branch controls and produces the next instruction address. It also provides start/halt sequencing and a saturating cycle counter for the core. The ALU's zero flag is sampled combinationally in the same cycle it is produced; all state updates occur on the rising clock edge.

## Interface
- PC_W, 10, program counter width in bits; address space is 2^PC_W words.
- CNT_W, 16, cycle counter width in bits.

- CLK  input  1  clock; all state updates occur on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  begin execution from address 0; honoured in IDLE and HALTED only.
- HALT  input  1  the current instruction is a halt (from decode).
- STALL  input  1  hold the PC this cycle (multi-cycle instruction in flight).
- BRANCH_EN  input  1  the current instruction is a conditional branch.
- BR_NZ  input  1  condition select: 0 = branch if ZERO=1; 1 = branch if ZERO=0.
- BR_ABS  input  1  target mode: 1 = absolute TARGET; 0 = PC-relative OFFSET.
- ZERO  input  1  zero flag from the ALU for the current instruction.
- TARGET  input  PC_W  absolute branch target (from the branch lookup table).
- OFFSET  input  8  signed two's-complement relative displacement.
- PC  output  PC_W  current instruction address (registered).
- TAKEN  output  1  registered; high for one cycle after a taken branch, used for fetch flush.
- DONE  output  1  registered; high while in HALTED.
- CYCLE_CNT  output  CNT_W  RUN cycles since the last START; saturating.

## Operation
- States: IDLE (reset state), RUN, HALTED.
- IDLE:
  - PC holds 0; DONE=0; counter holds.
  - START=1 -> RUN; PC<=0; CYCLE_CNT<=0.
- RUN, evaluated in strict priority order each cycle:
  1. STALL=1: PC holds; HALT and branch inputs are ignored; TAKEN<=0.
  2. HALT=1: -> HALTED; PC holds; DONE<=1; TAKEN<=0.
  3. Branch taken, when BRANCH_EN=1 and (ZERO XOR BR_NZ)=1:
     - PC<=TARGET if BR_ABS=1.
     - PC<=PC + sign-extend(OFFSET) to PC_W if BR_ABS=0, truncated modulo 2^PC_W.
     - TAKEN<=1.
  4. Otherwise: PC<=PC+1 modulo 2^PC_W; TAKEN<=0.
  - START is ignored in RUN.
- HALTED:
  - PC holds the halt address; DONE=1; counter holds.
  - START=1 -> RUN; PC<=0; CYCLE_CNT<=0; DONE<=0.
- CYCLE_CNT:
  - Increments by 1 on every clock edge spent in RUN, including stalled cycles and the cycle that takes HALT.
  - Saturates at 2^CNT_W-1; it never wraps.
- Wrap-around:
  - Sequential increment from 2^PC_W-1 gives 0.
  - Relative branches wrap in both directions; no error is flagged.
- TAKEN is never asserted while in IDLE or HALTED.

## Timing
- Reset (RESET_N low, asynchronous, takes effect immediately, including mid-RUN): state=IDLE, PC=0, TAKEN=0, DONE=0, CYCLE_CNT=0.
- Reset release: the first edge with RESET_N high may accept START.
- Next-PC latency is one cycle. Inputs sampled at edge N determine PC, TAKEN and DONE visible after edge N.
- ZERO, BRANCH_EN, TARGET and OFFSET must be stable before the edge of the cycle whose PC they belong to.
- TAKEN pulses for exactly one cycle per taken branch. Back-to-back taken branches give consecutive TAKEN cycles.
- DONE rises one edge after HALT is sampled and falls one edge after START is sampled in HALTED.
- START and HALT on the same edge in RUN: HALT is taken and START is ignored.

## Test plan
- Reset then START pulse, no branches, 5 cycles -> PC sequence 0,1,2,3,4,5; CYCLE_CNT=5; TAKEN and DONE stay 0.
- At PC=20, BRANCH_EN=1, BR_NZ=0, ZERO=1, BR_ABS=0, OFFSET=-4 (0xFC) -> PC=16 next cycle, TAKEN=1 for one cycle. Same stimulus with ZERO=0 -> PC=21, TAKEN=0.
- At PC=1023, no branch -> PC=0. At PC=2, relative OFFSET=-3 taken -> PC=1023. At PC=7, BR_ABS=1, TARGET=300 taken -> PC=300.
- At PC=8, STALL=1 for 3 cycles with HALT=1 and a taken branch asserted -> PC stays 8; no state change; CYCLE_CNT +3. Release STALL with HALT=1 -> HALTED, DONE=1, PC=8.
- In HALTED, START=1 -> PC=0, DONE=0, CYCLE_CNT=0, RUN resumes.
- Mid-RUN at PC=50, RESET_N low between clock edges -> PC=0 and outputs cleared immediately. Force CYCLE_CNT near 0xFFFF with a long RUN -> holds at 0xFFFF.
